// File: rtl/cacheline_adapter_pkg.sv
// ============================================================================
// Module      : cacheline_adapter_pkg
// Description : Shared cache types: line/burst geometry and datapath mux
//               selects used by cache_control and the cacheline adapter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cacheline_adapter_pkg;

    localparam int unsigned DEFAULT_LINE_WIDTH  = 256;
    localparam int unsigned DEFAULT_BURST_WIDTH = 64;
    localparam int unsigned DEFAULT_BEATS       = DEFAULT_LINE_WIDTH / DEFAULT_BURST_WIDTH;

    // Byte-offset bits inside one 32-byte line; cleared on the burst address.
    localparam int unsigned LINE_OFFSET_BITS    = 5;
    localparam logic [31:0] LINE_ADDR_MASK      = ~((32'd1 << LINE_OFFSET_BITS) - 32'd1);

    typedef enum logic [1:0] {
        PMEMADDR_CPU   = 2'd0,
        PMEMADDR_WB    = 2'd1
    } pmemaddr_mux_sel_t;

    typedef enum logic [1:0] {
        DATAIN_CPU     = 2'd0,
        DATAIN_PMEM    = 2'd1
    } datain_mux_sel_t;

endpackage

`default_nettype wire

// File: rtl/cacheline_adapter.sv
// ============================================================================
// Module      : cacheline_adapter
// Description : Splits one cache-line read/write into BEATS bursts on the
//               memory bus and returns a single-cycle completion pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cacheline_adapter
    import cacheline_adapter_pkg::*;
#(
    parameter int unsigned LINE_WIDTH  = DEFAULT_LINE_WIDTH,
    parameter int unsigned BURST_WIDTH = DEFAULT_BURST_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [31:0]            pmem_address,
    input  logic                   pmem_read,
    input  logic                   pmem_write,
    input  logic [LINE_WIDTH-1:0]  pmem_wdata,
    output logic [LINE_WIDTH-1:0]  pmem_rdata,
    output logic                   pmem_resp,
    output logic [31:0]            mem_address,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic [BURST_WIDTH-1:0] mem_wdata,
    input  logic [BURST_WIDTH-1:0] mem_rdata,
    input  logic                   mem_resp
);

    localparam int unsigned BEATS  = LINE_WIDTH / BURST_WIDTH;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                 state_q;
    logic [BEAT_W-1:0]      beat_q;
    logic [31:0]            addr_q;
    logic [LINE_WIDTH-1:0]  line_q;
    logic [LINE_WIDTH-1:0]  rdata_q;
    logic                   resp_q;
    logic                   mem_read_q;
    logic                   mem_write_q;
    logic                   last_beat;

    assign last_beat = (beat_q == BEAT_W'(BEATS - 1));

    // line_q doubles as the write source and the read assembly buffer, so the
    // visible read line only changes once a read burst has fully completed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            addr_q      <= '0;
            line_q      <= '0;
            rdata_q     <= '0;
            resp_q      <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    resp_q <= 1'b0;
                    if (pmem_write) begin
                        addr_q      <= pmem_address & LINE_ADDR_MASK;
                        line_q      <= pmem_wdata;
                        beat_q      <= '0;
                        mem_write_q <= 1'b1;
                        state_q     <= ST_WRITE;
                    end else if (pmem_read) begin
                        addr_q      <= pmem_address & LINE_ADDR_MASK;
                        beat_q      <= '0;
                        mem_read_q  <= 1'b1;
                        state_q     <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (mem_resp) begin
                        line_q[int'(beat_q)*BURST_WIDTH +: BURST_WIDTH] <= mem_rdata;
                        beat_q <= beat_q + BEAT_W'(1);
                        if (last_beat) begin
                            rdata_q    <= {mem_rdata, line_q[LINE_WIDTH-BURST_WIDTH-1:0]};
                            mem_read_q <= 1'b0;
                            resp_q     <= 1'b1;
                            state_q    <= ST_DONE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (mem_resp) begin
                        beat_q <= beat_q + BEAT_W'(1);
                        if (last_beat) begin
                            mem_write_q <= 1'b0;
                            resp_q      <= 1'b1;
                            state_q     <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    resp_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    resp_q      <= 1'b0;
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign pmem_rdata  = rdata_q;
    assign pmem_resp   = resp_q;
    assign mem_address = addr_q;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_wdata   = (state_q == ST_WRITE) ?
                         line_q[int'(beat_q)*BURST_WIDTH +: BURST_WIDTH] : '0;

endmodule

`default_nettype wire
